// File: rtl/ptcalc_pkg.sv
// Shared constants for the ptcalc multiply-accumulate pipeline.
// Default operand/result widths and DOUT clip limits.
package ptcalc_pkg;

  localparam int DIN0_W_DEF    = 19;
  localparam int DIN1_W_DEF    = 12;
  localparam int DOUT_W_DEF    = 31;
  localparam int ACC_GUARD_DEF = 8;

  localparam logic signed [DOUT_W_DEF-1:0] DOUT_MAX =
    {1'b0, {(DOUT_W_DEF-1){1'b1}}};
  localparam logic signed [DOUT_W_DEF-1:0] DOUT_MIN =
    {1'b1, {(DOUT_W_DEF-1){1'b0}}};

endpackage

// File: rtl/ptcalc_pipe_mac_satrnd.sv
// Round-half-up arithmetic shift followed by signed saturation.
// Purely combinational; one extra bit keeps the rounding add exact.
module ptcalc_pipe_mac_satrnd #(
  parameter int ACC_WIDTH  = 39,
  parameter int DOUT_WIDTH = 31,
  parameter int SHIFT      = 0
) (
  input  logic [ACC_WIDTH-1:0]  sum,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int RW = ACC_WIDTH + 1;

  localparam logic [RW-1:0] RND = ((RW)'(1) << SHIFT) >> 1;

  localparam logic signed [RW-1:0] MAXV =
    (RW)'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] rnd;

  assign ext    = $signed({sum[ACC_WIDTH-1], sum});
  assign biased = ext + $signed(RND);
  assign rnd    = biased >>> SHIFT;

  always_comb begin
    sat  = 1'b0;
    dout = rnd[DOUT_WIDTH-1:0];
    if (rnd > MAXV) begin
      sat  = 1'b1;
      dout = MAXV[DOUT_WIDTH-1:0];
    end else if (rnd < MINV) begin
      sat  = 1'b1;
      dout = MINV[DOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ptcalc_pipe_mac.sv
// Pipelined signed multiply-accumulate with round/saturate output.
// Whole pipe advances on ce = !out_valid | out_ready.
module ptcalc_pipe_mac
  import ptcalc_pkg::*;
#(
  parameter int DIN0_WIDTH = DIN0_W_DEF,
  parameter int DIN1_WIDTH = DIN1_W_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ACC_GUARD  = ACC_GUARD_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat
);

  localparam int PW        = DIN0_WIDTH + DIN1_WIDTH;
  localparam int ACC_WIDTH = PW + ACC_GUARD;
  localparam int PD        = NUM_STAGE - 2;

  logic ce;

  assign ce       = !out_valid | out_ready;
  assign in_ready = ce;

  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic                         acc1;
  logic                         v1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) v1 <= 1'b0;
    else if (ce)   v1 <= in_valid;
  end

  always_ff @(posedge ap_clk) begin
    if (ce) begin
      a_q  <= din0;
      b_q  <= din1;
      acc1 <= in_acc;
    end
  end

  logic signed [PW-1:0] prod_n;
  logic                 acc_n;
  logic                 v_n;

  generate
    if (PD == 0) begin : g_comb
      assign prod_n = PW'(a_q) * PW'(b_q);
      assign acc_n  = acc1;
      assign v_n    = v1;
    end else begin : g_pipe
      logic signed [PW-1:0] p_q [PD];
      logic [PD-1:0]        pv;
      logic [PD-1:0]        pa;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          pv <= '0;
        end else if (ce) begin
          pv[0] <= v1;
          for (int i = 1; i < PD; i++) pv[i] <= pv[i-1];
        end
      end

      // Unreset product registers let the multiply map into DSP regs.
      always_ff @(posedge ap_clk) begin
        if (ce) begin
          p_q[0] <= PW'(a_q) * PW'(b_q);
          pa[0]  <= acc1;
          for (int i = 1; i < PD; i++) begin
            p_q[i] <= p_q[i-1];
            pa[i]  <= pa[i-1];
          end
        end
      end

      assign prod_n = p_q[PD-1];
      assign acc_n  = pa[PD-1];
      assign v_n    = pv[PD-1];
    end
  endgenerate

  logic [ACC_WIDTH-1:0]  acc_r;
  logic [ACC_WIDTH-1:0]  sum;
  logic [DOUT_WIDTH-1:0] dout_n;
  logic                  sat_n;

  assign sum = (acc_n ? acc_r : '0) + ACC_WIDTH'(prod_n);

  ptcalc_pipe_mac_satrnd #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .SHIFT      (SHIFT)
  ) u_satrnd (
    .sum  (sum),
    .dout (dout_n),
    .sat  (sat_n)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      acc_r     <= '0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= v_n;
      if (v_n) begin
        acc_r   <= sum;
        dout    <= dout_n;
        out_sat <= sat_n;
      end
    end
  end

endmodule

// File: tb/tb_ptcalc_pipe_mac.sv
// Directed bench for ptcalc_pipe_mac: default and SHIFT=4 instances.
// Both instances see the same stimulus; results are queued per instance.
module tb_ptcalc_pipe_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic        in_acc = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [30:0] dout0, dout1;
  logic        sat0, sat1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  ptcalc_pipe_mac dut0 (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .din0      (din0),
    .din1      (din1),
    .in_acc    (in_acc),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .dout      (dout0),
    .out_sat   (sat0)
  );

  ptcalc_pipe_mac #(.SHIFT(4)) dut1 (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .din0      (din0),
    .din1      (din1),
    .in_acc    (in_acc),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .dout      (dout1),
    .out_sat   (sat1)
  );

  // A transfer happens at the next posedge when valid and ready are high.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) q0.push_back({sat0, dout0});
    if (rst_n && out_valid1 && out_ready) q1.push_back({sat1, dout1});
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pop0(input string tag, input int d, input int s);
    logic [31:0] e;
    chk({tag, "_avail"}, q0.size() > 0, 1);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk(tag, $signed(e[30:0]), d);
      chk({tag, "_sat"}, e[31], s);
    end
  endtask

  task automatic pop1(input string tag, input int d, input int s);
    logic [31:0] e;
    chk({tag, "_avail"}, q1.size() > 0, 1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk(tag, $signed(e[30:0]), d);
      chk({tag, "_sat"}, e[31], s);
    end
  endtask

  task automatic beat(input int a, input int b, input bit acc);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    din0     = a[18:0];
    din1     = b[11:0];
    in_acc   = acc;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  int sent;

  initial begin
    // reset state
    #12;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_in_ready", in_ready0, 1);
    rst_n = 1'b1;

    // latency and min*min product
    beat(-262144, -2048, 0);
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("lat_valid_c%0d", k), out_valid0, (k == 3));
    end
    chk("minmin_dout", $signed(dout0), 536870912);
    chk("minmin_sat", sat0, 0);
    repeat (3) idle();
    q0.delete();
    q1.delete();

    // back-to-back accumulate
    beat(3, 4, 0);
    beat(5, -2, 1);
    beat(7, 1, 1);
    idle();
    repeat (5) idle();
    pop0("b2b_0", 12, 0);
    pop0("b2b_1", 2, 0);
    pop0("b2b_2", 9, 0);
    chk("b2b_extra", q0.size(), 0);
    q1.delete();

    // max*max accumulate into saturation
    beat(262143, 2047, 0);
    beat(262143, 2047, 1);
    beat(262143, 2047, 1);
    idle();
    repeat (5) idle();
    pop0("mx_0", 536606721, 0);
    pop0("mx_1", 1073213442, 0);
    pop0("mx_2", 1073741823, 1);
    q1.delete();

    // stall with out_ready low for cycles 4..7
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      out_ready = !(c >= 4 && c <= 7);
      if (sent < 8) begin
        in_valid = 1'b1;
        din0     = 19'(sent + 1);
        din1     = 12'd2;
        in_acc   = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c == 5) chk("stall_rdy_c5", in_ready0, 0);
      if (c == 7) chk("stall_rdy_c7", in_ready0, 0);
      if (c == 9) chk("stall_rdy_c9", in_ready0, 1);
      if (in_valid && in_ready0) sent++;
    end
    chk("stall_sent", sent, 8);
    chk("stall_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) pop0($sformatf("stall_%0d", i), 2 * (i + 1), 0);
    q1.delete();

    // SHIFT=4 rounding on the second instance
    beat(25, 1, 0);
    beat(-24, 1, 0);
    beat(-25, 1, 0);
    idle();
    repeat (5) idle();
    pop1("rnd_25", 2, 0);
    pop1("rnd_m24", -1, 0);
    pop1("rnd_m25", -2, 0);
    pop0("raw_25", 25, 0);
    pop0("raw_m24", -24, 0);
    pop0("raw_m25", -25, 0);

    // reset with beats in flight
    out_ready = 1'b0;
    beat(100, 1, 0);
    beat(50, 1, 1);
    idle();
    repeat (3) idle();
    chk("inflight_valid", out_valid0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid0, 0);
    chk("async_rst_dout", dout0, 0);
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    q0.delete();
    q1.delete();
    beat(3, 4, 1);
    idle();
    repeat (5) idle();
    chk("post_rst_count", q0.size(), 1);
    pop0("post_rst", 12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
